test_output_tracer: RTL and testbench
=====================================

Name: test_output_tracer

Overview:
- Downstream consumer of the processor's 32-bit test data output (testDataOut).
- Detects every change of that value and pushes it into an on-chip circular FIFO, which a bench or debug host drains through a read handshake.
- Raises a sticky halted flag when the output stays unchanged for a programmable number of sampled cycles, giving the bench a deterministic end-of-program condition.

Parameters:
- DATA_W, 32, width of the traced value.
- DEPTH, 16, FIFO entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- STALL_LIMIT, 1024, number of consecutive unchanged sampled cycles that sets halted; range 1 to 65535.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- test_data_in  input  DATA_W  processor test output value.
- sample_en  input  1  qualifies test_data_in in the current cycle.
- rd_en  input  1  pop request.
- rd_data  output  DATA_W  popped entry, registered.
- rd_valid  output  1  one-cycle strobe marking rd_data as valid.
- count  output  ADDR_W+1  current occupancy, 0 to DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a push was dropped.
- halted  output  1  sticky: stall limit reached.

Behaviour:
- Reset values, applied asynchronously while rst=1:
  - rd_data=0, rd_valid=0, count=0, full=0, empty=1, overflow=0, halted=0.
  - Read and write pointers = 0, last-value register = 0, first-sample flag = 1, stall counter = 0.
- Change detect: push_req = sample_en && (first_flag || test_data_in != last_val).
  - When sample_en=1: last_val <= test_data_in and first_flag <= 0.
  - The first sampled value after reset is always pushed, including 0.
- Push:
  - Accepted when push_req && (!full || pop_ok).
  - Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH; pointers wrap naturally.
- Pop:
  - pop_ok = rd_en && !empty.
  - rd_data <= mem[rd_ptr] and rd_ptr increments, all in the same edge.
  - rd_valid=1 for exactly the following cycle; otherwise 0.
  - rd_data holds its last popped value when no pop occurs.
  - rd_en while empty is ignored: no strobe, no state change.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, a pop in the same cycle makes room, so the push is accepted.
  - When empty, the pop is ignored (no read-through) and the push is accepted.
- Overflow:
  - A push_req while full && !pop_ok drops the data, and overflow <= 1 until reset.
  - FIFO contents and pointers are unaffected.
- Latency: a value at test_data_in in cycle N is poppable from cycle N+1; rd_valid rises in the cycle after rd_en is sampled.
- Stall counter (16 bits), updated only while halted=0:
  - Cleared whenever push_req=1.
  - Incremented on sample_en && !push_req.
  - Holds when sample_en=0.
  - When the counter reaches STALL_LIMIT, halted <= 1 on that same edge.
- Once set, halted stays 1 until reset and the counter freezes. Later changes are still traced but do not clear halted.
- count, full and empty are registered and consistent with the pointers after every edge.
- Reset asserted mid-operation discards all entries at once; there is no partial pop and rd_valid is forced to 0.

Optional Feature:
- Macro TRACER_TIMESTAMP_EN.
- When defined:
  - A free-running 16-bit cycle counter (reset 0, wraps 0xFFFF→0) is stored alongside each entry.
  - An extra port rd_stamp (output, 16) is registered with rd_data and is reset to 0.
  - The stamp is the counter value in the cycle of the push.
- When undefined:
  - No counter, no stamp storage and no rd_stamp port.
  - All other behaviour is identical.

Test Plan:
- Reset, then sample_en=1 with test_data_in=0x00000000 for 3 cycles -> exactly one push; count=1; rd_en pulse -> rd_valid for one cycle with rd_data=0x00000000; empty=1.
- Drive 0x11, 0x11, 0x22, 0x33, 0x33 on consecutive sampled cycles -> count=3; three pops return 0x11, 0x22, 0x33 in order.
- Push 17 distinct values with no reads (DEPTH=16) -> full=1, count=16, overflow=1; the 17th value is absent; drain returns the first 16 values in order with pointer wrap.
- When full, a new value arrives in the same cycle as rd_en -> count stays 16, overflow stays 0, oldest entry popped, new value appended last.
- STALL_LIMIT=4, constant 0x5 sampled -> halted rises on the 5th sampled cycle (first is a push, then 4 stalls); toggling sample_en=0 mid-run freezes the count; async rst mid-drain -> all outputs return to reset values immediately.
- With TRACER_TIMESTAMP_EN: push at cycle counter 7, pop -> rd_stamp=7 alongside rd_data.

Source files
------------

// File: rtl/test_output_tracer.sv
// Traces changes of the processor test output into a circular FIFO and flags a stalled program.
// Optional macro TRACER_TIMESTAMP_EN stores a 16-bit cycle stamp with each entry (rd_stamp port).
module test_output_tracer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] test_data_in,
  input  logic              sample_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              halted
`ifdef TRACER_TIMESTAMP_EN
  ,
  output logic [15:0]       rd_stamp
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     STALL_MAX = 16'(STALL_LIMIT);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] last_val;
  logic              first_flag;
  logic [15:0]       stall_cnt;
  logic [15:0]       stall_inc;
  logic [ADDR_W:0]   count_next;

  logic push_req;
  logic pop_ok;
  logic push_ok;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_req  = sample_en && (first_flag || (test_data_in != last_val));
  assign pop_ok    = rd_en && !empty;
  assign push_ok   = push_req && (!full || pop_ok);
  assign stall_inc = stall_cnt + 16'd1;

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + 1'b1;
    else if (!push_ok && pop_ok)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= test_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      last_val   <= '0;
      first_flag <= 1'b1;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_req && full && !pop_ok)
        overflow <= 1'b1;
      if (sample_en) begin
        last_val   <= test_data_in;
        first_flag <= 1'b0;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  // Stall detection freezes once halted so the end-of-program flag is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      halted    <= 1'b0;
    end else if (!halted) begin
      if (push_req) begin
        stall_cnt <= '0;
      end else if (sample_en) begin
        stall_cnt <= stall_inc;
        if (stall_inc == STALL_MAX)
          halted <= 1'b1;
      end
    end
  end

`ifdef TRACER_TIMESTAMP_EN
  logic [15:0] cycle_cnt;
  logic [15:0] stamp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push_ok)
      stamp_mem[wr_ptr] <= cycle_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      rd_stamp  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 16'd1;
      if (pop_ok)
        rd_stamp <= stamp_mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_test_output_tracer.sv
// Directed plus randomized bench for test_output_tracer, checked against a queue-based model.
module tb_test_output_tracer;

  localparam int DEPTH = 16;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] test_data_in = '0;
  logic        sample_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        halted;
`ifdef TRACER_TIMESTAMP_EN
  logic [15:0] rd_stamp;
`endif

  int passes = 0;
  int total  = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [15:0] sq[$];
  logic [31:0] m_last;
  bit          m_first;
  int          m_stall;
  bit          m_halted;
  bit          m_over;
  bit          m_valid;
  logic [31:0] m_rdata;
  logic [15:0] m_rstamp;
  int          cyc;

  test_output_tracer #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(4), .STALL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .test_data_in(test_data_in), .sample_en(sample_en),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .halted(halted)
`ifdef TRACER_TIMESTAMP_EN
    , .rd_stamp(rd_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic checkAll();
    checkOutput("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
    checkOutput("rd_data", rd_data, m_rdata);
    checkOutput("count", {27'b0, count}, q.size());
    checkOutput("full", {31'b0, full}, {31'b0, (q.size() == DEPTH)});
    checkOutput("empty", {31'b0, empty}, {31'b0, (q.size() == 0)});
    checkOutput("overflow", {31'b0, overflow}, {31'b0, m_over});
    checkOutput("halted", {31'b0, halted}, {31'b0, m_halted});
`ifdef TRACER_TIMESTAMP_EN
    checkOutput("rd_stamp", {16'b0, rd_stamp}, {16'b0, m_rstamp});
`endif
  endtask

  task automatic modelReset();
    q.delete();
    sq.delete();
    m_last   = '0;
    m_first  = 1'b1;
    m_stall  = 0;
    m_halted = 1'b0;
    m_over   = 1'b0;
    m_valid  = 1'b0;
    m_rdata  = '0;
    m_rstamp = '0;
    cyc      = 0;
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous clear at once.
  task automatic applyReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    sample_en = 1'b0;
    rd_en     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model by the spec rules, then compare.
  task automatic applyStimulus(input logic se, input logic [31:0] d, input logic re);
    bit preq;
    bit pop;
    sample_en    = se;
    test_data_in = d;
    rd_en        = re;
    preq = se && (m_first || d != m_last);
    pop  = re && (q.size() != 0);
    m_valid = pop;
    if (pop) begin
      m_rdata  = q.pop_front();
      m_rstamp = sq.pop_front();
    end
    if (preq) begin
      if (q.size() < DEPTH) begin
        q.push_back(d);
        sq.push_back(cyc[15:0]);
      end else begin
        m_over = 1'b1;
      end
    end
    if (se) begin
      m_last  = d;
      m_first = 1'b0;
    end
    if (!m_halted) begin
      if (preq) m_stall = 0;
      else if (se) begin
        m_stall++;
        if (m_stall == LIMIT) m_halted = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    modelReset();
    applyReset();

    // First sample (zero) pushed once, repeats ignored, then popped
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("zero_once_count", {27'b0, count}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("zero_pop_valid", {31'b0, rd_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("valid_one_cycle", {31'b0, rd_valid}, 32'd0);

    // Change detection with repeats
    applyReset();
    applyStimulus(1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0);
    checkOutput("three_pushes", {27'b0, count}, 32'd3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // 17 distinct pushes overflow, then drain with pointer wrap
    applyReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 32'h100 + i, 1'b0);
    checkOutput("ovf_set", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Full FIFO with simultaneous push and pop
    applyReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h200 + i, 1'b0);
    applyStimulus(1'b1, 32'h2AA, 1'b1);
    checkOutput("full_swap_count", {27'b0, count}, 32'd16);
    checkOutput("full_swap_ovf", {31'b0, overflow}, 32'd0);
    // Empty FIFO with simultaneous push and pop: no read-through
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h3BB, 1'b1);
    checkOutput("empty_swap_valid", {31'b0, rd_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Stall limit with sample_en gaps, then reset mid-drain
    applyReset();
    applyStimulus(1'b1, 32'h5, 1'b0);
    applyStimulus(1'b1, 32'h5, 1'b0);
    applyStimulus(1'b0, 32'h5, 1'b0);
    applyStimulus(1'b0, 32'h5, 1'b0);
    applyStimulus(1'b1, 32'h5, 1'b0);
    applyStimulus(1'b1, 32'h5, 1'b0);
    checkOutput("not_yet_halted", {31'b0, halted}, 32'd0);
    applyStimulus(1'b1, 32'h5, 1'b0);
    checkOutput("halted_set", {31'b0, halted}, 32'd1);
    applyStimulus(1'b1, 32'h6, 1'b0);
    applyStimulus(1'b1, 32'h7, 1'b1);
    applyReset();

`ifdef TRACER_TIMESTAMP_EN
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h77, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("stamp_7", {16'b0, rd_stamp}, 32'd7);
    applyReset();
`endif

    // Randomized traffic with periodic resets
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) applyReset();
      else applyStimulus(1'($urandom_range(0, 3) != 0),
                         32'hA0 + 32'($urandom_range(0, 3)),
                         1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
